mul_rr_sched: RTL and testbench

- Shares one sequential zero-skipping shift-and-add multiply engine between N_REQ requesters.
- A round-robin arbiter grants one request at a time, latches that request's operands and sequences the engine. The engine spends one cycle per set bit of the multiplier and skips runs of zeros.
- Returns the product with the requester ID over a valid/ready handshake.
- Sits between requesting client blocks and the shared multiplier resource.

---
 rtl/mul_rr_sched_pkg.sv | 22 ++
 rtl/mul_rr_sched_lsb_index.sv | 26 ++
 rtl/mul_rr_sched.sv | 143 ++++++++++++++
 tb/tb_mul_rr_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rr_sched_pkg.sv
// Shared types and sizing helpers for the round-robin multiply scheduler.
// Exports the FSM state encoding and width helpers for the requester ID
// and for the bit-index produced by the lowest-set-bit encoder.
package mul_rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester ID width: clog2(n), but never narrower than one bit.
    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to name one bit position of a w-bit operand.
    function automatic int calc_kw(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_sched_lsb_index.sv
// Combinational lowest-set-bit encoder.
// Ports: vec (W bits in), idx (index of lowest set bit, 0 when vec is 0),
//        zero (high when vec has no bits set).
module mul_rr_sched_lsb_index
    import mul_rr_sched_pkg::*;
#(
    parameter int W  = 4,
    parameter int KW = calc_kw(W)
) (
    input  logic [W-1:0]  vec,
    output logic [KW-1:0] idx,
    output logic          zero
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx  = '0;
        zero = (vec == '0);
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = KW'(i);
            end
        end
    end

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one zero-skipping shift-and-add multiplier
// between N_REQ requesters; returns product plus owner ID on valid/ready.
// Ports: clk, rst (async active-low), req/a_in/b_in per requester, gnt
//        (one-hot, combinational), busy, out_valid/out_ready/out_id/product.
module mul_rr_sched
    import mul_rr_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 4,
    parameter int IDW   = calc_idw(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDW-1:0]     out_id,
    output logic [2*W-1:0]     product
);

    localparam int KW = calc_kw(W);

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     rem;
    logic [2*W-1:0]   acc;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   ptr;

    logic [IDW-1:0]   win;
    logic             win_found;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic [KW-1:0]    k;
    logic             rem_zero;
    logic [2*W-1:0]   a_wide;

    // Rotating-priority search: start just after the last winner and wrap.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            int cand;
            cand = int'(ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req[IDW'(cand)]) begin
                win_found = 1'b1;
                win       = IDW'(cand);
            end
        end
    end

    // Grant only from IDLE and never while reset is applied, so a grant can
    // never be shown for an edge that will not capture the operands.
    always_comb begin
        gnt = '0;
        if (rst && (state == IDLE) && win_found) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = a_in[i*W +: W];
                b_sel = b_in[i*W +: W];
            end
        end
    end

    mul_rr_sched_lsb_index #(
        .W  (W),
        .KW (KW)
    ) u_lsb_index (
        .vec  (rem),
        .idx  (k),
        .zero (rem_zero)
    );

    // The shift uses the absolute bit position in the original multiplier,
    // so the multiplicand register never moves and no running shift exists.
    assign a_wide = {{W{1'b0}}, a_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            rem       <= '0;
            acc       <= '0;
            id        <= '0;
            ptr       <= IDW'(N_REQ - 1);
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        a_reg <= a_sel;
                        rem   <= b_sel;
                        acc   <= '0;
                        id    <= win;
                        ptr   <= win;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rem_zero) begin
                        product   <= acc;
                        out_id    <= id;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // Cannot overflow: the sum never exceeds (2^W-1)^2.
                        acc <= acc + (a_wide << k);
                        rem <= rem & ~(W'(1) << k);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rr_sched.sv
module tb_mul_rr_sched;

    localparam int N_REQ = 2;
    localparam int W     = 4;
    localparam int IDW   = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic [2*W-1:0]     product;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ptr;

    mul_rr_sched #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .product   (product)
    );

    always #5 clk = ~clk;

    // Reference arbiter: first held request searching from last winner + 1.
    function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] r);
        for (int off = 1; off <= N_REQ; off++) begin
            int c;
            c = (ptr + off) % N_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int r);
        logic [N_REQ-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and observe it up to the first cycle of out_valid.
    task automatic run_op(input int r, input int a, input int b,
                          output logic [N_REQ-1:0] g, output logic [N_REQ-1:0] g_after,
                          output logic busy_after, output int lat,
                          output int prod, output int id);
        req[r] = 1'b1;
        a_in[r*W +: W] = W'(a);
        b_in[r*W +: W] = W'(b);
        g = '0; g_after = '0; busy_after = 1'b0; prod = -1; id = -1; lat = -1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (gnt != '0) begin
                g = gnt;
                break;
            end
            @(posedge clk);
        end
        if (g == '0) begin
            req[r] = 1'b0;
            return;
        end
        step();
        g_after    = gnt;
        busy_after = busy;
        req[r]     = 1'b0;
        a_in[r*W +: W] = W'($urandom);
        b_in[r*W +: W] = W'($urandom);
        exp_ptr = g[1] ? 1 : 0;
        lat = 0;
        while (!out_valid && lat < W + 4) begin
            step();
            lat++;
        end
        prod = int'(product);
        id   = int'(out_id);
    endtask

    task automatic finish_op(input int stall);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) step();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 2'b11; a_in = '0; b_in = '0; out_ready = 1'b0;
        step(); step(); step();
        n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt got=%b want=00", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_id !== '0) begin n_err++; $display("FAIL reset_id got=%0d want=0", out_id); end
        n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product got=%0d want=0", product); end
        req = '0;
        rst = 1'b1;
        exp_ptr = N_REQ - 1;
        step();
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] g, ga;
        logic ba;
        int lat, p, id;
        out_ready = 1'b1;
        run_op(0, 5, 11, g, ga, ba, lat, p, id);
        n_cmp++; if (g !== 2'b01) begin n_err++; $display("FAIL single_gnt got=%b want=01", g); end
        n_cmp++; if (ga !== 2'b00) begin n_err++; $display("FAIL single_gnt_pulse got=%b want=00", ga); end
        n_cmp++; if (ba !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b want=1", ba); end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL single_latency got=%0d want=4", lat); end
        n_cmp++; if (p !== 55) begin n_err++; $display("FAIL single_product got=%0d want=55", p); end
        n_cmp++; if (id !== 0) begin n_err++; $display("FAIL single_id got=%0d want=0", id); end
        finish_op(0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_accept_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_accept_busy got=%b want=0", busy); end
    endtask

    task automatic test_boundary();
        int ta[4] = '{9, 15, 0, 1};
        int tb[4] = '{0, 15, 13, 8};
        logic [N_REQ-1:0] g, ga;
        logic ba;
        int lat, p, id;
        for (int i = 0; i < 4; i++) begin
            run_op(0, ta[i], tb[i], g, ga, ba, lat, p, id);
            n_cmp++; if (p !== ta[i] * tb[i]) begin n_err++; $display("FAIL boundary_product a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], p, ta[i] * tb[i]); end
            n_cmp++; if (lat !== $countones(tb[i]) + 1) begin n_err++; $display("FAIL boundary_latency b=%0d got=%0d want=%0d", tb[i], lat, $countones(tb[i]) + 1); end
            finish_op(0);
        end
    endtask

    task automatic test_round_robin();
        int opa[N_REQ];
        int opb[N_REQ];
        int e, ea, eb, t;
        for (int r = 0; r < N_REQ; r++) begin
            opa[r] = $urandom_range(0, 15);
            opb[r] = $urandom_range(0, 15);
            a_in[r*W +: W] = W'(opa[r]);
            b_in[r*W +: W] = W'(opb[r]);
        end
        req = 2'b11;
        out_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            t = 0;
            #1;
            while (gnt == '0 && t < 20) begin step(); t++; end
            e = rr_pick(exp_ptr, req);
            n_cmp++; if (gnt !== onehot(e)) begin n_err++; $display("FAIL rr_order op=%0d got=%b want=%b", op, gnt, onehot(e)); end
            ea = opa[e]; eb = opb[e];
            step();
            exp_ptr = e;
            // The winner may now change its operands; the latched copy must be used.
            opa[e] = $urandom_range(0, 15);
            opb[e] = $urandom_range(0, 15);
            a_in[e*W +: W] = W'(opa[e]);
            b_in[e*W +: W] = W'(opb[e]);
            #1;
            n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL rr_no_gnt_in_run got=%b want=00", gnt); end
            t = 0;
            while (!out_valid && t < W + 4) begin step(); t++; end
            n_cmp++; if (int'(product) !== ea * eb) begin n_err++; $display("FAIL rr_product op=%0d got=%0d want=%0d", op, product, ea * eb); end
            n_cmp++; if (int'(out_id) !== e) begin n_err++; $display("FAIL rr_id op=%0d got=%0d want=%0d", op, out_id, e); end
            step();
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        logic [N_REQ-1:0] g, ga;
        logic ba;
        int lat, p, id, a, b, a0, b0;
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
        a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15);
        out_ready = 1'b0;
        run_op(1, a, b, g, ga, ba, lat, p, id);
        req[0] = 1'b1;
        a_in[0 +: W] = W'(a0);
        b_in[0 +: W] = W'(b0);
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (int'(product) !== a * b) begin n_err++; $display("FAIL bp_product cyc=%0d got=%0d want=%0d", c, product, a * b); end
            n_cmp++; if (out_id !== 1'b1) begin n_err++; $display("FAIL bp_id cyc=%0d got=%0d want=1", c, out_id); end
            n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_busy_valid cyc=%0d got=%b%b want=11", c, busy, out_valid); end
            n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL bp_gnt cyc=%0d got=%b want=00", c, gnt); end
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept got=%b%b want=00", busy, out_valid); end
        n_cmp++; if (gnt !== onehot(rr_pick(exp_ptr, 2'b01))) begin n_err++; $display("FAIL bp_next_gnt got=%b want=01", gnt); end
        run_op(0, a0, b0, g, ga, ba, lat, p, id);
        n_cmp++; if (p !== a0 * b0) begin n_err++; $display("FAIL bp_next_product got=%0d want=%0d", p, a0 * b0); end
        finish_op(0);
    endtask

    task automatic test_reset_mid_run();
        int t;
        out_ready = 1'b1;
        req[1] = 1'b1;
        a_in[W +: W] = W'(7);
        b_in[W +: W] = W'(15);
        t = 0;
        #1;
        while (gnt == '0 && t < 20) begin step(); t++; end
        step();
        req = '0;
        step();
        step();
        rst = 1'b0;
        req = 2'b11;
        #1;
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy_valid got=%b%b want=00", busy, out_valid); end
        n_cmp++; if (product !== '0 || out_id !== '0) begin n_err++; $display("FAIL mid_reset_result got=%0d/%0d want=0/0", product, out_id); end
        n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL mid_reset_gnt got=%b want=00", gnt); end
        step();
        req = '0;
        rst = 1'b1;
        exp_ptr = N_REQ - 1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_stale cyc=%0d got=%b want=0", c, out_valid); end
        end
        req = 2'b11;
        #1;
        n_cmp++; if (gnt !== onehot(rr_pick(exp_ptr, 2'b11))) begin n_err++; $display("FAIL mid_reset_first_gnt got=%b want=01", gnt); end
        req = '0;
        step();
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] g, ga;
        logic ba;
        int lat, p, id, r, a, b;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, N_REQ - 1);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            run_op(r, a, b, g, ga, ba, lat, p, id);
            n_cmp++; if (g !== onehot(r)) begin n_err++; $display("FAIL rand_gnt n=%0d got=%b want=%b", n, g, onehot(r)); end
            n_cmp++; if (p !== a * b || id !== r) begin n_err++; $display("FAIL rand_result n=%0d got=%0d/%0d want=%0d/%0d", n, p, id, a * b, r); end
            n_cmp++; if (lat !== $countones(b) + 1) begin n_err++; $display("FAIL rand_latency n=%0d got=%0d want=%0d", n, lat, $countones(b) + 1); end
            finish_op($urandom_range(0, 3));
        end
    endtask

    task automatic test_exhaustive();
        logic [N_REQ-1:0] g, ga;
        logic ba;
        int lat, p, id;
        out_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1, a, b, g, ga, ba, lat, p, id);
                n_cmp++; if (p !== a * b) begin n_err++; $display("FAIL exh_product a=%0d b=%0d got=%0d want=%0d", a, b, p, a * b); end
                n_cmp++; if (lat !== $countones(b) + 1) begin n_err++; $display("FAIL exh_latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, $countones(b) + 1); end
                n_cmp++; if (id !== 1) begin n_err++; $display("FAIL exh_id a=%0d b=%0d got=%0d want=1", a, b, id); end
                finish_op(0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
